// File: rtl/cpu_common.sv
// Shared CPU types used by the issue stage.
// Register addresses, writeback ports and scoreboard request bundle.
package cpu_common;

    localparam int WB_PORTS = 4;

    typedef logic [4:0] regaddr_t;
    typedef logic [1:0] wbport_t;

    typedef struct packed {
        regaddr_t rs1;
        logic     rs1_used;
        regaddr_t rs2;
        logic     rs2_used;
        regaddr_t rd;
        logic     rd_write;
        wbport_t  port;
    } sb_req_t;

endpackage

// File: rtl/issue_operand_check.sv
// Per-operand hazard check against the busy/tag state.
// Reports a pending hazard or a same-cycle forward source.
module issue_operand_check
    import cpu_common::*;
#(
    parameter int REG_COUNT = 32
) (
    input  regaddr_t                  rs,
    input  logic                      used,
    input  logic    [REG_COUNT-1:0]   busy,
    input  wbport_t [REG_COUNT-1:0]   tag,
    input  logic    [REG_COUNT-1:0]   clr,
    output logic                      pend,
    output logic                      fwd_valid,
    output wbport_t                   fwd_port
);

    // Busy and not retiring stalls; busy and retiring now forwards.
    always_comb begin
        pend      = 1'b0;
        fwd_valid = 1'b0;
        fwd_port  = '0;
        if (used && busy[rs]) begin
            if (clr[rs]) begin
                fwd_valid = 1'b1;
                fwd_port  = tag[rs];
            end else begin
                pend = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Register scoreboard and issue scheduler for the issue stage.
// Tracks outstanding results and their writeback port.
module issue_scoreboard #(
    parameter int WB_PORTS  = cpu_common::WB_PORTS,
    parameter int REG_COUNT = 32,
    parameter int CNT_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [4:0]            req_rs1_i,
    input  logic                  req_rs1_used_i,
    input  logic [4:0]            req_rs2_i,
    input  logic                  req_rs2_used_i,
    input  logic [4:0]            req_rd_i,
    input  logic                  req_rd_write_i,
    input  logic [1:0]            req_port_i,
    input  logic [5*WB_PORTS-1:0] wb_addr_i,
    input  logic [WB_PORTS-1:0]   wb_valid_i,
    output logic                  fwd_rs1_valid_o,
    output logic [1:0]            fwd_rs1_port_o,
    output logic                  fwd_rs2_valid_o,
    output logic [1:0]            fwd_rs2_port_o,
    output logic [REG_COUNT-1:0]  busy_o,
    output logic                  wb_error_o,
    output logic [CNT_W-1:0]      stall_count_o
);

    import cpu_common::*;

    sb_req_t                  req;
    logic    [REG_COUNT-1:0]  busy_r;
    wbport_t [REG_COUNT-1:0]  tag_r;
    logic    [REG_COUNT-1:0]  clr;
    logic                     pend1;
    logic                     pend2;
    logic                     fwd1_v;
    logic                     fwd2_v;
    wbport_t                  fwd1_p;
    wbport_t                  fwd2_p;
    logic                     waw;
    logic                     ready;
    logic                     fire;
    logic                     bad_wb;
    logic                     err_r;
    logic    [CNT_W-1:0]      cnt_r;

    assign req = '{
        rs1:      req_rs1_i,
        rs1_used: req_rs1_used_i,
        rs2:      req_rs2_i,
        rs2_used: req_rs2_used_i,
        rd:       req_rd_i,
        rd_write: req_rd_write_i,
        port:     req_port_i
    };

    // A busy register retires when its own producer port writes it back.
    always_comb begin
        clr = '0;
        for (int r = 1; r < REG_COUNT; r++) begin
            if (busy_r[r] && wb_valid_i[tag_r[r]] &&
                wb_addr_i[int'(tag_r[r])*5 +: 5] == regaddr_t'(r)) begin
                clr[r] = 1'b1;
            end
        end
    end

    // Any non-zero writeback not owned by that port is unexpected.
    always_comb begin
        bad_wb = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid_i[p] && wb_addr_i[p*5 +: 5] != '0) begin
                if (!(busy_r[wb_addr_i[p*5 +: 5]] &&
                      tag_r[wb_addr_i[p*5 +: 5]] == wbport_t'(p))) begin
                    bad_wb = 1'b1;
                end
            end
        end
    end

    issue_operand_check #(.REG_COUNT(REG_COUNT)) u_rs1 (
        .rs        (req.rs1),
        .used      (req.rs1_used),
        .busy      (busy_r),
        .tag       (tag_r),
        .clr       (clr),
        .pend      (pend1),
        .fwd_valid (fwd1_v),
        .fwd_port  (fwd1_p)
    );

    issue_operand_check #(.REG_COUNT(REG_COUNT)) u_rs2 (
        .rs        (req.rs2),
        .used      (req.rs2_used),
        .busy      (busy_r),
        .tag       (tag_r),
        .clr       (clr),
        .pend      (pend2),
        .fwd_valid (fwd2_v),
        .fwd_port  (fwd2_p)
    );

    // Destination still owned by an older producer blocks issue.
    always_comb begin
        waw = req.rd_write && req.rd != '0 &&
              busy_r[req.rd] && !clr[req.rd];
    end

    // Grant is gated off while reset is held.
    always_comb begin
        ready           = rst_ni && !(pend1 || pend2 || waw);
        fire            = req_valid_i && ready;
        req_ready_o     = ready;
        fwd_rs1_valid_o = rst_ni && fwd1_v;
        fwd_rs1_port_o  = rst_ni ? fwd1_p : '0;
        fwd_rs2_valid_o = rst_ni && fwd2_v;
        fwd_rs2_port_o  = rst_ni ? fwd2_p : '0;
    end

    // Retire on writeback, then reserve rd on issue; set wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_r <= '0;
            tag_r  <= '0;
        end else begin
            busy_r <= busy_r & ~clr;
            if (fire && req.rd_write && req.rd != '0) begin
                busy_r[req.rd] <= 1'b1;
                tag_r[req.rd]  <= req.port;
            end
        end
    end

    // Sticky unexpected-writeback flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
        end else if (bad_wb) begin
            err_r <= 1'b1;
        end
    end

    // Saturating count of cycles a valid request was held off.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= '0;
        end else if (req_valid_i && !ready && cnt_r != '1) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign busy_o        = busy_r;
    assign wb_error_o    = err_r;
    assign stall_count_o = cnt_r;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard.
// Registered results go through an expected-value queue.
module tb_issue_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  rs1;
    logic        rs1_used;
    logic [4:0]  rs2;
    logic        rs2_used;
    logic [4:0]  rd;
    logic        rd_write;
    logic [1:0]  port;
    logic [19:0] wb_addr;
    logic [3:0]  wb_valid;
    logic        f1_v;
    logic [1:0]  f1_p;
    logic        f2_v;
    logic [1:0]  f2_p;
    logic [31:0] busy;
    logic        wb_err;
    logic [3:0]  cnt;

    int checks;
    int failures;
    logic [31:0] exp_q[$];
    logic [31:0] exp_b;

    issue_scoreboard #(.WB_PORTS(4), .REG_COUNT(32), .CNT_W(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_rs1_i       (rs1),
        .req_rs1_used_i  (rs1_used),
        .req_rs2_i       (rs2),
        .req_rs2_used_i  (rs2_used),
        .req_rd_i        (rd),
        .req_rd_write_i  (rd_write),
        .req_port_i      (port),
        .wb_addr_i       (wb_addr),
        .wb_valid_i      (wb_valid),
        .fwd_rs1_valid_o (f1_v),
        .fwd_rs1_port_o  (f1_p),
        .fwd_rs2_valid_o (f2_v),
        .fwd_rs2_port_o  (f2_p),
        .busy_o          (busy),
        .wb_error_o      (wb_err),
        .stall_count_o   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 0;
        rs1 = 0; rs1_used = 0;
        rs2 = 0; rs2_used = 0;
        rd = 0; rd_write = 0; port = 0;
        wb_addr = '0; wb_valid = '0;
    endtask

    task automatic drive_req(input logic [4:0] a1, input logic u1,
                             input logic [4:0] a2, input logic u2,
                             input logic [4:0] d, input logic w,
                             input logic [1:0] p);
        req_valid = 1;
        rs1 = a1; rs1_used = u1;
        rs2 = a2; rs2_used = u2;
        rd = d; rd_write = w; port = p;
    endtask

    task automatic drive_wb(input int p, input logic [4:0] a);
        wb_valid[p] = 1'b1;
        wb_addr[p*5 +: 5] = a;
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        drive_req(5'd1, 1, 5'd2, 1, 5'd3, 1, 2'd0);
        #3;
        checks++;
        if (req_ready !== 1'b0 || busy !== '0 || wb_err !== 1'b0 ||
            cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset: ready=%b busy=%h err=%b cnt=%0d want 0",
                     req_ready, busy, wb_err, cnt);
        end
        step();
        rst_n = 1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL t1_ready: got %b want 1", req_ready);
        end
        exp_q.push_back(32'h0000_0008);
        step();
        idle();
        exp_b = exp_q.pop_front();
        checks++;
        if (busy !== exp_b) begin
            failures++;
            $display("FAIL t1_busy: got %h want %h", busy, exp_b);
        end
        checks++;
        if (cnt !== 4'd0) begin
            failures++;
            $display("FAIL t1_cnt: got %0d want 0", cnt);
        end
    endtask

    task automatic test_raw_forward();
        drive_req(5'd3, 1, 5'd0, 0, 5'd0, 0, 2'd0);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL t2_stall: got %b want 0", req_ready);
        end
        step();
        step();
        step();
        checks++;
        if (cnt !== 4'd3) begin
            failures++;
            $display("FAIL t2_cnt: got %0d want 3", cnt);
        end
        drive_wb(0, 5'd3);
        #1;
        checks++;
        if (req_ready !== 1'b1 || f1_v !== 1'b1 || f1_p !== 2'd0 ||
            f2_v !== 1'b0) begin
            failures++;
            $display("FAIL t2_fwd: ready=%b f1v=%b f1p=%0d f2v=%b want 1 1 0 0",
                     req_ready, f1_v, f1_p, f2_v);
        end
        exp_q.push_back(32'h0);
        step();
        idle();
        exp_b = exp_q.pop_front();
        checks++;
        if (busy !== exp_b || cnt !== 4'd3) begin
            failures++;
            $display("FAIL t2_clear: busy=%h cnt=%0d want %h 3",
                     busy, cnt, exp_b);
        end
    endtask

    task automatic test_waw();
        drive_req(5'd0, 0, 5'd0, 0, 5'd5, 1, 2'd2);
        step();
        drive_req(5'd0, 0, 5'd0, 0, 5'd5, 1, 2'd1);
        #1;
        checks++;
        if (req_ready !== 1'b0 || busy !== 32'h20) begin
            failures++;
            $display("FAIL t3_stall: ready=%b busy=%h want 0 00000020",
                     req_ready, busy);
        end
        step();
        drive_wb(2, 5'd5);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL t3_resolve: got %b want 1", req_ready);
        end
        exp_q.push_back(32'h20);
        step();
        idle();
        exp_b = exp_q.pop_front();
        checks++;
        if (busy !== exp_b || cnt !== 4'd4) begin
            failures++;
            $display("FAIL t3_setwins: busy=%h cnt=%0d want %h 4",
                     busy, cnt, exp_b);
        end
        drive_req(5'd0, 0, 5'd5, 1, 5'd0, 0, 2'd0);
        req_valid = 0;
        drive_wb(1, 5'd5);
        #1;
        checks++;
        if (f2_v !== 1'b1 || f2_p !== 2'd1 || f1_v !== 1'b0) begin
            failures++;
            $display("FAIL t3_newtag: f2v=%b f2p=%0d f1v=%b want 1 1 0",
                     f2_v, f2_p, f1_v);
        end
        exp_q.push_back(32'h0);
        step();
        idle();
        exp_b = exp_q.pop_front();
        checks++;
        if (busy !== exp_b || wb_err !== 1'b0) begin
            failures++;
            $display("FAIL t3_retire: busy=%h err=%b want %h 0",
                     busy, wb_err, exp_b);
        end
    endtask

    task automatic test_zero_reg();
        drive_req(5'd0, 1, 5'd0, 1, 5'd0, 1, 2'd3);
        #1;
        checks++;
        if (req_ready !== 1'b1 || f1_v !== 1'b0) begin
            failures++;
            $display("FAIL t4_ready: ready=%b f1v=%b want 1 0",
                     req_ready, f1_v);
        end
        exp_q.push_back(32'h0);
        step();
        idle();
        exp_b = exp_q.pop_front();
        checks++;
        if (busy !== exp_b) begin
            failures++;
            $display("FAIL t4_busy: got %h want %h", busy, exp_b);
        end
    endtask

    task automatic test_wb_error();
        drive_wb(1, 5'd7);
        exp_q.push_back(32'h0);
        step();
        idle();
        exp_b = exp_q.pop_front();
        checks++;
        if (busy !== exp_b || wb_err !== 1'b1) begin
            failures++;
            $display("FAIL t5_stray: busy=%h err=%b want %h 1",
                     busy, wb_err, exp_b);
        end
        step();
        checks++;
        if (wb_err !== 1'b1) begin
            failures++;
            $display("FAIL t5_sticky: got %b want 1", wb_err);
        end
        pulse_reset();
        drive_req(5'd0, 0, 5'd0, 0, 5'd9, 1, 2'd3);
        step();
        idle();
        drive_wb(0, 5'd9);
        drive_wb(3, 5'd9);
        #1;
        checks++;
        if (wb_err !== 1'b0 || busy !== 32'h200) begin
            failures++;
            $display("FAIL t5_pre: err=%b busy=%h want 0 00000200",
                     wb_err, busy);
        end
        exp_q.push_back(32'h0);
        step();
        idle();
        exp_b = exp_q.pop_front();
        checks++;
        if (busy !== exp_b || wb_err !== 1'b1) begin
            failures++;
            $display("FAIL t5_dual: busy=%h err=%b want %h 1",
                     busy, wb_err, exp_b);
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        drive_req(5'd0, 0, 5'd0, 0, 5'd10, 1, 2'd0);
        step();
        drive_req(5'd0, 0, 5'd10, 1, 5'd0, 0, 2'd0);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stall: got %b want 0", req_ready);
        end
        drive_wb(3, 5'd10);
        #1;
        checks++;
        if (req_ready !== 1'b0 || f2_v !== 1'b0) begin
            failures++;
            $display("FAIL b2b_wrongport: ready=%b f2v=%b want 0 0",
                     req_ready, f2_v);
        end
        wb_valid = '0;
        drive_wb(0, 5'd10);
        #1;
        checks++;
        if (req_ready !== 1'b1 || f2_v !== 1'b1 || f2_p !== 2'd0) begin
            failures++;
            $display("FAIL b2b_fwd: ready=%b f2v=%b f2p=%0d want 1 1 0",
                     req_ready, f2_v, f2_p);
        end
        exp_q.push_back(32'h0);
        step();
        idle();
        exp_b = exp_q.pop_front();
        checks++;
        if (busy !== exp_b || cnt !== 4'd0 || wb_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: busy=%h cnt=%0d err=%b want %h 0 0",
                     busy, cnt, wb_err, exp_b);
        end
    endtask

    task automatic test_saturate_reset();
        drive_req(5'd0, 0, 5'd0, 0, 5'd11, 1, 2'd1);
        step();
        drive_req(5'd11, 1, 5'd0, 0, 5'd0, 0, 2'd0);
        for (int i = 0; i < 14; i++) step();
        checks++;
        if (cnt !== 4'd14) begin
            failures++;
            $display("FAIL t6_cnt14: got %0d want 14", cnt);
        end
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (cnt !== 4'd15) begin
            failures++;
            $display("FAIL t6_sat: got %0d want 15", cnt);
        end
        drive_wb(1, 5'd11);
        #1;
        checks++;
        if (f1_v !== 1'b1 || f1_p !== 2'd1) begin
            failures++;
            $display("FAIL t6_prefwd: f1v=%b f1p=%0d want 1 1", f1_v, f1_p);
        end
        rst_n = 0;
        #1;
        checks++;
        if (req_ready !== 1'b0 || f1_v !== 1'b0 || f2_v !== 1'b0 ||
            busy !== '0 || cnt !== 4'd0 || wb_err !== 1'b0) begin
            failures++;
            $display("FAIL t6_async: ready=%b f1v=%b busy=%h cnt=%0d err=%b",
                     req_ready, f1_v, busy, cnt, wb_err);
        end
        wb_valid = '0;
        step();
        rst_n = 1;
        #1;
        checks++;
        if (busy !== '0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL t6_release: busy=%h ready=%b want 0 1",
                     busy, req_ready);
        end
        idle();
        drive_wb(1, 5'd11);
        step();
        idle();
        checks++;
        if (wb_err !== 1'b1) begin
            failures++;
            $display("FAIL t6_stale: got %b want 1", wb_err);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_raw_forward();
        test_waw();
        test_zero_reg();
        test_wb_error();
        test_back_to_back();
        test_saturate_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
Register scoreboard and issue scheduler for the CPU issue stage. It tracks which architectural registers have a result still outstanding, and which writeback port will deliver each one. It grants or stalls the decoded instruction at issue, and tells the issue datapath when a source operand must be taken from a same-cycle writeback port instead of the register file. It sits between stage_decode and stage_issue and observes the four writeback ports.

Parameters:
WB_PORTS, 4, number of writeback ports observed; also the number of producer tags.
REG_COUNT, 32, number of architectural registers; register 0 is hardwired zero.
CNT_W, 32, width of the saturating stall counter.

Ports:
clk_i  in  1  CPU clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  decoded instruction present
req_ready_o  out  1  instruction may issue this cycle
req_rs1_i  in  5  source 1 register address
req_rs1_used_i  in  1  source 1 is read
req_rs2_i  in  5  source 2 register address
req_rs2_used_i  in  1  source 2 is read
req_rd_i  in  5  destination register address
req_rd_write_i  in  1  instruction writes rd
req_port_i  in  2  writeback port that will return rd
wb_addr_i  in  5*WB_PORTS  per-port writeback register address; port p occupies [5p+4:5p]
wb_valid_i  in  WB_PORTS  per-port writeback strobe
fwd_rs1_valid_o  out  1  source 1 comes from a writeback port this cycle
fwd_rs1_port_o  out  2  port supplying source 1
fwd_rs2_valid_o  out  1  source 2 comes from a writeback port this cycle
fwd_rs2_port_o  out  2  port supplying source 2
busy_o  out  REG_COUNT  registered busy vector, for debug display
wb_error_o  out  1  sticky: an unexpected writeback was seen
stall_count_o  out  CNT_W  saturating count of stalled request cycles

Behaviour:
- Reset and clocking:
  - One clock domain.
  - rst_ni is asynchronous assert, synchronous deassert by the upstream reset synchronizer.
  - While rst_ni is low: busy_r='0, tag_r='0, wb_error_o=0, stall_count_o=0.
  - While rst_ni is low, req_ready_o and all fwd_*_valid_o are forced 0.
- State held per register r: busy_r[r] and tag_r[r] (2 bits, the producer port).
  - busy_r[0] is constant 0.
  - busy_o = busy_r.
- Writeback clear match (combinational):
  - clr[r] = busy_r[r] && wb_valid_i[tag_r[r]] && wb_addr_i[tag_r[r]]==r.
- Source hazard, for each rsN:
  - pend = rsN_used && busy_r[rsN] && !clr[rsN].
  - If rsN_used && busy_r[rsN] && clr[rsN]: fwd_rsN_valid_o=1 and fwd_rsN_port_o=tag_r[rsN].
  - Otherwise fwd_rsN_valid_o=0 and fwd_rsN_port_o=0.
- WAW hazard: waw = rd_write && rd!=0 && busy_r[rd] && !clr[rd].
- Readiness and issue:
  - req_ready_o = !(pend1 || pend2 || waw).
  - req_ready_o is combinational, zero latency, and independent of req_valid_i.
  - fire = req_valid_i && req_ready_o.
- Registered update, evaluated in this order each cycle:
  1. busy_r[r] cleared where clr[r].
  2. On fire with rd_write && rd!=0: busy_r[rd]=1 and tag_r[rd]=req_port_i.
  - Set wins over clear on the same register in the same cycle.
  - rd==0 never sets busy.
- Error flag:
  - A valid writeback on port p whose address is not busy, or whose register has tag_r!=p, is ignored.
  - Such a writeback sets wb_error_o, which stays set until reset.
  - Address 0 writebacks are ignored silently.
- Simultaneous writebacks: two ports writing the same address in one cycle → only the tag-matching port clears; the other sets wb_error_o.
- Stall counter: increments when req_valid_i && !req_ready_o and saturates at all-ones. There is no wrap.
- Issue latency: an instruction is granted in the same cycle its hazards resolve. A dependent instruction issued the cycle after its producer fires sees busy=1 and stalls.
- Reset mid-operation: all outstanding reservations are discarded. Writebacks arriving after reset for pre-reset issues set wb_error_o; this is the intended signature.

Decomposition:
- Add to cpu_common:
  - regaddr_t (5 bits)
  - wbport_t (2 bits)
  - WB_PORTS constant
  - scoreboard request struct {rs1, rs1_used, rs2, rs2_used, rd, rd_write, port}
- One sub-module: issue_operand_check.
  - Combinational, instantiated twice.
  - Inputs: rs, used, busy, tag, clr.
  - Outputs: pend, fwd_valid, fwd_port.
- The top holds state, the WAW check, the error flag and the counter.

Test Plan:
1. Reset, then request rs1=1, rs2=2, rd=3, port=0 → ready=1, fire. Next cycle busy_o[3]=1, tag_r[3]=0. Stall counter stays 0.
2. With r3 busy on port 0, request rs1=3 → ready=0 and stall_count increments each cycle. Then wb_valid[0]=1, wb_addr[0]=3 → that cycle ready=1, fwd_rs1_valid=1, fwd_rs1_port=0. Next cycle busy_o[3]=0.
3. WAW: r5 busy on port 2; request rd=5, port 1 → stall. Writeback port 2 addr 5 same cycle as the request → fire; busy_o[5]=1 with tag 1 (set wins).
4. rd=0 with rd_write=1 → busy_o stays 0. A source rs1=0 never stalls.
5. Writeback port 1 addr 7 while r7 is not busy → no busy change; wb_error_o=1 and it stays 1. Ports 0 and 3 both write r9 with tag 3 → busy_o[9] clears, wb_error_o=1.
6. Hold a stall for 2^CNT_W cycles (use CNT_W=4 override) → count saturates at 15. Assert rst_ni mid-stall → all outputs 0 asynchronously; after release busy_o=0 and ready=1.
